// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM engine: register map, CTRL bit layout,
// the packed configuration record and the operating-mode encoding.
package pwm_pkg;

   localparam int REG_W = 8;

   localparam int CTRL_IDX  = 0;
   localparam int PRESC_IDX = 1;
   localparam int TOP_IDX   = 2;
   localparam int DUTY0_IDX = 3;
   localparam int DUTY1_IDX = 4;

   // Only reg0..reg4 carry configuration; the rest of the bank is ignored.
   localparam int CFG_NREGS = 5;

   localparam int CTRL_EN0  = 0;
   localparam int CTRL_EN1  = 1;
   localparam int CTRL_INV0 = 2;
   localparam int CTRL_INV1 = 3;

   typedef struct packed {
      logic [REG_W-1:0] ctrl;
      logic [REG_W-1:0] presc;
      logic [REG_W-1:0] top;
      logic [REG_W-1:0] duty0;
      logic [REG_W-1:0] duty1;
   } pwm_cfg_t;

   typedef enum logic {
      MODE_IDLE = 1'b0,
      MODE_RUN  = 1'b1
   } mode_e;

   function automatic logic any_enabled(input pwm_cfg_t cfg);
      return cfg.ctrl[CTRL_EN0] | cfg.ctrl[CTRL_EN1];
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: compare the shared period counter against this channel's
// duty value, apply enable/inversion and register the result so the pin
// never sees combinational glitches.
module pwm_channel
   import pwm_pkg::*;
(
   input  logic             clk100,
   input  logic             reset_n,
   input  logic [REG_W-1:0] cnt_i,
   input  logic [REG_W-1:0] duty_i,
   input  logic             en_i,
   input  logic             inv_i,
   output logic             pwm_o
);

   logic pwm_d;
   logic pwm_q;

   // Disabled channels park at their inactive level, which is the invert bit.
   always_comb begin
      pwm_d = inv_i;
      if (en_i) begin
         pwm_d = (cnt_i < duty_i) ^ inv_i;
      end
   end

   // Output register; one cycle behind the counter value it was derived from.
   always_ff @(posedge clk100) begin
      if (!reset_n) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_engine.sv
// Two-channel PWM engine fed from the I2C register bank.
//
// mode      | meaning
// ----------+---------------------------------------------------------------
// MODE_IDLE | both shadow enables clear; counters parked at 0, shadows
//           | reload on every cycle the sampled configuration is stable
// MODE_RUN  | at least one shadow enable set; prescaler and period counter
//           | run, shadows reload only at the period wrap
//
// Mode is decoded from the shadow enables rather than held in its own
// register, so a shadow load that clears both enables drops to idle on
// the very next cycle.
module pwm_engine
   import pwm_pkg::*;
#(
   parameter int DW    = 8,
   parameter int NREGS = 9
) (
   input  logic              clk100,
   input  logic              reset_n,
   input  logic [DW*NREGS-1:0] registers_packed,
   output logic [1:0]        pwm,
   output logic              period_tick,
   output logic              active
);

   pwm_cfg_t         cfg_in;
   pwm_cfg_t         cfg_q, cfg_qq;
   pwm_cfg_t         sh_q, sh_d;
   logic [REG_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [REG_W-1:0] cnt_q, cnt_d;
   logic             period_tick_q, period_tick_d;
   logic             active_q, active_d;
   logic             stable;
   logic             tick;
   logic             wrap;
   mode_e            mode;
   logic             unused_bits;

   // Pick the five configuration bytes out of the flat register bank.
   always_comb begin
      cfg_in       = '0;
      cfg_in.ctrl  = registers_packed[CTRL_IDX*DW  +: REG_W];
      cfg_in.presc = registers_packed[PRESC_IDX*DW +: REG_W];
      cfg_in.top   = registers_packed[TOP_IDX*DW   +: REG_W];
      cfg_in.duty0 = registers_packed[DUTY0_IDX*DW +: REG_W];
      cfg_in.duty1 = registers_packed[DUTY1_IDX*DW +: REG_W];
   end

   // Bytes beyond DUTY1 and the spare CTRL bits carry no function here.
   assign unused_bits = ^{registers_packed[DW*NREGS-1:DW*CFG_NREGS], sh_q.ctrl[REG_W-1:4]};

   // The bank is written from the slow I2C clock; two equal consecutive
   // samples mean no write is in flight, so a load cannot catch a torn value.
   assign stable = (cfg_q == cfg_qq);
   assign mode   = any_enabled(sh_q) ? MODE_RUN : MODE_IDLE;
   assign tick   = (pre_cnt_q == sh_q.presc);
   assign wrap   = tick && (cnt_q == sh_q.top);

   // Timebase and shadow-load decisions.
   always_comb begin
      sh_d          = sh_q;
      pre_cnt_d     = pre_cnt_q;
      cnt_d         = cnt_q;
      period_tick_d = 1'b0;
      active_d      = any_enabled(sh_q);
      unique case (mode)
         MODE_IDLE: begin
            pre_cnt_d = '0;
            cnt_d     = '0;
            if (stable) begin
               sh_d = cfg_q;
            end
         end
         MODE_RUN: begin
            if (tick) begin
               pre_cnt_d = '0;
               if (wrap) begin
                  cnt_d         = '0;
                  period_tick_d = 1'b1;
                  if (stable) begin
                     sh_d = cfg_q;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               pre_cnt_d = pre_cnt_q + 1'b1;
            end
         end
         default: begin
            pre_cnt_d = '0;
            cnt_d     = '0;
         end
      endcase
   end

   // Sample pipeline, shadows, counters and status flags.
   always_ff @(posedge clk100) begin
      if (!reset_n) begin
         cfg_q         <= '0;
         cfg_qq        <= '0;
         sh_q          <= '0;
         pre_cnt_q     <= '0;
         cnt_q         <= '0;
         period_tick_q <= 1'b0;
         active_q      <= 1'b0;
      end else begin
         cfg_q         <= cfg_in;
         cfg_qq        <= cfg_q;
         sh_q          <= sh_d;
         pre_cnt_q     <= pre_cnt_d;
         cnt_q         <= cnt_d;
         period_tick_q <= period_tick_d;
         active_q      <= active_d;
      end
   end

   pwm_channel u_ch0 (
      .clk100  (clk100),
      .reset_n (reset_n),
      .cnt_i   (cnt_q),
      .duty_i  (sh_q.duty0),
      .en_i    (sh_q.ctrl[CTRL_EN0]),
      .inv_i   (sh_q.ctrl[CTRL_INV0]),
      .pwm_o   (pwm[0])
   );

   pwm_channel u_ch1 (
      .clk100  (clk100),
      .reset_n (reset_n),
      .cnt_i   (cnt_q),
      .duty_i  (sh_q.duty1),
      .en_i    (sh_q.ctrl[CTRL_EN1]),
      .inv_i   (sh_q.ctrl[CTRL_INV1]),
      .pwm_o   (pwm[1])
   );

   assign period_tick = period_tick_q;
   assign active      = active_q;

endmodule

// File: tb/tb_pwm_engine.sv
// Bench for pwm_engine: directed scenarios followed by random traffic, every
// cycle compared against a period-level reference model.
module tb_pwm_engine;

   logic        clk100;
   logic        reset_n;
   logic [71:0] registers_packed;
   logic [1:0]  pwm;
   logic        period_tick;
   logic        active;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   // reference model state
   logic [7:0] m_q  [5];
   logic [7:0] m_qq [5];
   logic [7:0] m_sh [5];
   int         m_phase;
   logic [1:0] m_pwm;
   logic       m_tick;
   logic       m_active;

   // accumulators for directed window measurements
   int acc_hi0, acc_hi1, acc_ticks;

   pwm_engine #(.DW(8), .NREGS(9)) dut (
      .clk100           (clk100),
      .reset_n          (reset_n),
      .registers_packed (registers_packed),
      .pwm              (pwm),
      .period_tick      (period_tick),
      .active           (active)
   );

   initial clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
      end
   endtask

   task automatic set_reg(input int idx, input logic [7:0] val);
      registers_packed[8*idx +: 8] = val;
   endtask

   // One clock of the model: period position is a single phase index; the
   // period counter value is phase/(PRESC+1).
   task automatic model_edge();
      int  p, per, c;
      bit  stable, en0, en1, inv0, inv1;
      if (!reset_n) begin
         for (int i = 0; i < 5; i++) begin
            m_q[i] = 8'h00; m_qq[i] = 8'h00; m_sh[i] = 8'h00;
         end
         m_phase = 0; m_pwm = 2'b00; m_tick = 1'b0; m_active = 1'b0;
         return;
      end
      p      = int'(m_sh[1]) + 1;
      per    = p * (int'(m_sh[2]) + 1);
      c      = m_phase / p;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) if (m_q[i] != m_qq[i]) stable = 1'b0;
      en0  = m_sh[0][0]; en1 = m_sh[0][1];
      inv0 = m_sh[0][2]; inv1 = m_sh[0][3];
      m_pwm[0] = en0 ? ((c < int'(m_sh[3])) ^ inv0) : inv0;
      m_pwm[1] = en1 ? ((c < int'(m_sh[4])) ^ inv1) : inv1;
      m_active = en0 | en1;
      if (en0 | en1) begin
         if (m_phase == per - 1) begin
            m_phase = 0;
            m_tick  = 1'b1;
            if (stable) for (int i = 0; i < 5; i++) m_sh[i] = m_q[i];
         end else begin
            m_phase++;
            m_tick = 1'b0;
         end
      end else begin
         m_phase = 0;
         m_tick  = 1'b0;
         if (stable) for (int i = 0; i < 5; i++) m_sh[i] = m_q[i];
      end
      for (int i = 0; i < 5; i++) begin
         m_qq[i] = m_q[i];
         m_q[i]  = registers_packed[8*i +: 8];
      end
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk100);
         model_edge();
         #1;
         check("pwm", pwm, m_pwm);
         check("period_tick", period_tick, m_tick);
         check("active", active, m_active);
         acc_hi0   += int'(pwm[0]);
         acc_hi1   += int'(pwm[1]);
         acc_ticks += int'(period_tick);
      end
   endtask

   task automatic clear_acc();
      acc_hi0 = 0; acc_hi1 = 0; acc_ticks = 0;
   endtask

   task automatic wait_tick(input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         step(1);
         if (period_tick === 1'b1) seen = 1'b1;
      end
      check("tick_seen", seen, 1);
   endtask

   initial begin
      reset_n          = 1'b0;
      registers_packed = '0;
      clear_acc();
      step(2);
      check("rst_pwm", pwm, 0);
      check("rst_tick", period_tick, 0);
      check("rst_active", active, 0);
      reset_n = 1'b1;

      // 1: PRESC=0 TOP=9 DUTY0=3 EN0
      set_reg(1, 8'd0); set_reg(2, 8'd9); set_reg(3, 8'd3); set_reg(0, 8'h01);
      step(4);
      check("t1_active", active, 1);
      wait_tick(40);
      clear_acc();
      step(10);
      check("t1_hi0", acc_hi0, 3);
      check("t1_hi1", acc_hi1, 0);
      check("t1_ticks", acc_ticks, 1);

      // 2: DUTY0 3->7 mid-period
      wait_tick(40);
      clear_acc();
      step(2);
      set_reg(3, 8'd7);
      step(8);
      check("t2_cur_hi0", acc_hi0, 3);
      clear_acc();
      step(10);
      check("t2_next_hi0", acc_hi0, 7);
      check("t2_ticks", acc_ticks, 1);

      // 3: PRESC=4 TOP=9 DUTY1=5 EN1|INV1
      set_reg(1, 8'd4); set_reg(4, 8'd5); set_reg(0, 8'h0A);
      step(3);
      wait_tick(40);
      clear_acc();
      step(50);
      check("t3_hi1", acc_hi1, 25);
      check("t3_hi0", acc_hi0, 0);
      check("t3_ticks", acc_ticks, 1);

      // 4: DUTY0=0 then DUTY0=255
      set_reg(1, 8'd0); set_reg(3, 8'd0); set_reg(0, 8'h01);
      step(3);
      wait_tick(80);
      clear_acc();
      step(20);
      check("t4_zero_hi0", acc_hi0, 0);
      check("t4_zero_ticks", acc_ticks, 2);
      set_reg(3, 8'd255);
      step(3);
      wait_tick(40);
      clear_acc();
      step(20);
      check("t4_full_hi0", acc_hi0, 20);
      check("t4_full_ticks", acc_ticks, 2);

      // 5: unstable DUTY0 across a boundary keeps the old value
      set_reg(3, 8'd3);
      step(3);
      wait_tick(40);
      step(5);
      clear_acc();
      for (int k = 0; k < 8; k++) begin
         set_reg(3, (k % 2 == 1) ? 8'd7 : 8'd3);
         step(1);
      end
      step(7);
      check("t5_retained_hi0", acc_hi0, 3);
      clear_acc();
      step(10);
      check("t5_loaded_hi0", acc_hi0, 7);

      // 6: one-cycle reset mid-period
      wait_tick(40);
      step(4);
      reset_n = 1'b0;
      step(1);
      check("t6_pwm", pwm, 0);
      check("t6_tick", period_tick, 0);
      check("t6_active", active, 0);
      reset_n = 1'b1;
      step(1);
      check("t6_idle_active", active, 0);
      wait_tick(40);
      clear_acc();
      step(10);
      check("t6_hi0", acc_hi0, 7);

      // random traffic
      for (int it = 0; it < 30; it++) begin
         int run;
         set_reg(0, 8'($urandom_range(0, 255)));
         set_reg(1, 8'($urandom_range(0, 3)));
         set_reg(2, 8'($urandom_range(0, 12)));
         set_reg(3, ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 14)));
         set_reg(4, ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 14)));
         set_reg(5 + int'($urandom_range(0, 3)), 8'($urandom));
         run = int'($urandom_range(20, 150));
         for (int k = 0; k < run; k++) begin
            if ($urandom_range(0, 19) == 0)
               set_reg(int'($urandom_range(0, 8)), 8'($urandom_range(0, 14)));
            reset_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            step(1);
         end
         reset_n = 1'b1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pwm_engine.md
Name: pwm_engine

Overview:
- Consumes the 72-bit packed register file written over I2C (9 x 8-bit registers) and drives two glitch-free PWM outputs plus a period strobe.
- Sits directly downstream of the I2C slave register bank and replaces ad-hoc use of register bits for the PWM pins.
- Configuration is double-buffered: a new value takes effect only at a period boundary.

Parameters:
- DW, 8, register width in bits
- NREGS, 9, number of packed registers (input width DW*NREGS)

Ports:
- clk100  input  1  system clock
- reset_n  input  1  reset, synchronous, active-low
- registers_packed  input  72  register i occupies bits [8i+7:8i]; slow-changing and written from the divided I2C clock domain
- pwm  output  2  PWM outputs, registered
- period_tick  output  1  one-cycle pulse on each period wrap
- active  output  1  high while at least one shadow channel enable is set

Behaviour:
- Register map:
  - reg0 CTRL: bit0 EN0, bit1 EN1, bit2 INV0, bit3 INV1; other bits ignored.
  - reg1 PRESC.
  - reg2 TOP.
  - reg3 DUTY0.
  - reg4 DUTY1.
  - reg5..reg8 ignored.
- Reset (reset_n=0 at a clk100 edge): all counters, shadows and sample registers go to 0; pwm=2'b00, period_tick=0, active=0.
  - Reset mid-period aborts immediately.
  - The first cycle after release behaves as idle.
- Input sampling:
  - cfg_q <= registers_packed; cfg_qq <= cfg_q.
  - stable = (cfg_q == cfg_qq) over reg0..reg4 only.
  - Shadow loads take cfg_q, and only when stable=1.
  - If unstable at a load point, the shadows keep their old values for the next period. No partial loads: all five shadows load together or not at all.
- Idle (shadow EN0=EN1=0):
  - Shadows load every cycle in which stable=1.
  - pre_cnt and cnt are held at 0; period_tick=0.
- Running (any shadow EN set):
  - pre_cnt (8 bits) increments each cycle. When pre_cnt==PRESC it produces tick and wraps to 0, so the tick period is PRESC+1 cycles.
  - On tick, cnt (8 bits) increments. When cnt==TOP and tick are both true: cnt<=0, period_tick<=1 on the next cycle, and the shadows load (if stable).
  - Period = (PRESC+1)*(TOP+1) clk100 cycles.
  - If a shadow load clears both enables, the block returns to idle in the next cycle.
- Per-channel output, registered with 1-cycle latency relative to cnt:
  - pwm[i] <= EN_i ? ((cnt < DUTY_i) ^ INV_i) : INV_i.
  - DUTY=0 gives constant inactive; DUTY>TOP gives constant active (100%).
  - TOP=0: period is PRESC+1 cycles, and any DUTY>=1 gives constant active.
- Compare uses unsigned 8-bit arithmetic; no counter ever exceeds 255, since cnt<=TOP<=255.
- A CTRL/DUTY write mid-period never alters the current period's waveform.
- active is registered from the shadow enables.

Decomposition:
- Package pwm_pkg holds:
  - register index localparams CTRL_IDX=0, PRESC_IDX=1, TOP_IDX=2, DUTY0_IDX=3, DUTY1_IDX=4;
  - CTRL bit positions;
  - a packed struct pwm_cfg_t {ctrl, presc, top, duty0, duty1}.
- One sub-module, pwm_channel: compare, invert and output register for a single channel. Instantiated twice.
- The prescaler/period timebase and the shadow logic stay in pwm_engine.

Test Plan:
1. Reset, then PRESC=0, TOP=9, DUTY0=3, CTRL=0x01 -> pwm[0] is high 3 cycles then low 7, repeating every 10 cycles; period_tick pulses every 10 cycles; pwm[1]=0.
2. Same config, DUTY0 changed 3->7 mid-period -> the current period keeps 3 high cycles; the next period starts with 7 high cycles, aligned to period_tick.
3. PRESC=4, TOP=9, DUTY1=5, CTRL=0x0A (EN1, INV1) -> pwm[1] is low 25 cycles then high 25 cycles, period 50 cycles; pwm[0] held 0.
4. TOP=9 with DUTY0=0, then with DUTY0=255 (CTRL=0x01) -> pwm[0] is constant 0 / constant 1 for whole periods; period_tick still every 10 cycles.
5. Toggle a reg3 bit on alternate cycles across a boundary (stable=0 at the load point) -> the previous DUTY0 is retained for the following period; it loads at the first boundary with stable input.
6. reset_n=0 for 1 cycle mid-period while running -> next cycle pwm=0, period_tick=0, active=0; after release the block is idle until the enables are re-sampled, and the first period starts with cnt=0.
